// File: rtl/periph_bus_pkg.sv
// Shared definitions for initiators on the 0x4000_0000 peripheral bus.
package periph_bus_pkg;

    // Default peripheral window.
    localparam logic [31:0] DEFAULT_BASE_ADDR    = 32'h4000_0000;
    localparam logic [31:0] DEFAULT_WINDOW_BYTES = 32'd32;

    // Register byte offsets inside the window.
    localparam logic [7:0] REG_TH     = 8'h00;
    localparam logic [7:0] REG_TL     = 8'h04;
    localparam logic [7:0] REG_TCON   = 8'h08;
    localparam logic [7:0] REG_LED    = 8'h10;
    localparam logic [7:0] REG_SWITCH = 8'h14;
    localparam logic [7:0] REG_DIGI   = 8'h18;

    // Bus master sequencing: accept, strobe, capture, respond.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bus_state_t;

endpackage

// File: rtl/periph_addr_filter.sv
// Combinational pre-filter: flags word-misaligned and out-of-window addresses.
module periph_addr_filter
    import periph_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter logic [31:0] WINDOW_BYTES = DEFAULT_WINDOW_BYTES
) (
    input  logic [31:0] i_addr,
    output logic        o_misaligned,
    output logic        o_out_of_window
);

    // Inclusive last byte of the window; the window must not wrap past 2^32.
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + WINDOW_BYTES - 32'd1;

    assign o_misaligned    = (i_addr[1:0] != 2'b00);
    assign o_out_of_window = (i_addr < BASE_ADDR) || (i_addr > LAST_ADDR);

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: one request in, one single-cycle rd/wr strobe out,
// one response back. Bad addresses are answered locally without a bus access.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter logic [31:0] WINDOW_BYTES = DEFAULT_WINDOW_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        r_accessible,
    input  logic        w_accessible
);

    bus_state_t  r_state;
    logic        r_we;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    bus_state_t  w_state_nxt;
    logic        w_we_nxt;
    logic        w_rd_nxt;
    logic        w_wr_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic        w_resp_valid_nxt;
    logic [31:0] w_resp_rdata_nxt;
    logic        w_resp_err_nxt;

    logic        w_misaligned;
    logic        w_out_of_window;
    logic        w_reject;

    periph_addr_filter #(
        .BASE_ADDR    (BASE_ADDR),
        .WINDOW_BYTES (WINDOW_BYTES)
    ) u_addr_filter (
        .i_addr          (req_addr),
        .o_misaligned    (w_misaligned),
        .o_out_of_window (w_out_of_window)
    );

    assign w_reject = w_misaligned | w_out_of_window;

    // Next state and next registered outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_rd_nxt         = 1'b0;
        w_wr_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;

        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_we_nxt    = req_we;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    if (w_reject) begin
                        // Answer locally; the bus never sees this access.
                        w_state_nxt      = ST_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = 32'd0;
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        // Strobe is registered, so it is high for exactly the ISSUE cycle.
                        w_state_nxt = ST_ISSUE;
                        w_rd_nxt    = ~req_we;
                        w_wr_nxt    = req_we;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Responder data and acknowledge are valid only in this cycle.
                w_state_nxt      = ST_RESP;
                w_resp_valid_nxt = 1'b1;
                if (r_we) begin
                    w_resp_rdata_nxt = 32'd0;
                    w_resp_err_nxt   = ~w_accessible;
                end else begin
                    w_resp_rdata_nxt = r_accessible ? rdata : 32'd0;
                    w_resp_err_nxt   = ~r_accessible;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_resp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_rd         <= w_rd_nxt;
            r_wr         <= w_wr_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign rd         = r_rd;
    assign wr         = r_wr;
    assign addr       = r_addr;
    assign wdata      = r_wdata;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master with a small peripheral responder model.
module tb_periph_bus_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        r_accessible;
    logic        w_accessible;

    int n_checks;
    int n_fails;

    periph_bus_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .rd           (rd),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .r_accessible (r_accessible),
        .w_accessible (w_accessible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder model: registered read data and acknowledges, one cycle after the strobe.
    logic [31:0] th_q, tl_q, tcon_q, led_q, sw_q, digi_q;

    initial begin
        th_q = 32'd0; tl_q = 32'h0000_1234; tcon_q = 32'd0;
        led_q = 32'd0; sw_q = 32'h0000_003C; digi_q = 32'h0000_0007;
        rdata = 32'd0; r_accessible = 1'b0; w_accessible = 1'b0;
    end

    always @(posedge clk) begin
        if (rd) begin
            r_accessible <= 1'b1;
            case (addr)
                32'h4000_0000: rdata <= th_q;
                32'h4000_0004: rdata <= tl_q;
                32'h4000_0008: rdata <= tcon_q;
                32'h4000_0010: rdata <= led_q;
                32'h4000_0014: rdata <= sw_q;
                32'h4000_0018: rdata <= digi_q;
                default: begin rdata <= 32'd0; r_accessible <= 1'b0; end
            endcase
        end
        if (wr) begin
            w_accessible <= 1'b1;
            case (addr)
                32'h4000_0000: th_q   <= wdata;
                32'h4000_0004: tl_q   <= wdata;
                32'h4000_0008: tcon_q <= wdata;
                32'h4000_0010: led_q  <= wdata;
                32'h4000_0018: digi_q <= wdata;
                default: w_accessible <= 1'b0;
            endcase
        end
    end

    // Strobe monitor, sampled on the falling edge.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] strobe_addr = 32'd0;

    always @(negedge clk) begin
        if (rd) rd_cnt++;
        if (wr) wr_cnt++;
        if (rd && wr) both_cnt++;
        if (rd || wr) strobe_addr = addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Counts edges after the accept edge until resp_valid is seen; 0 means timeout.
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // Full transaction: present, accept, wait for response, consume it.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r_data, output logic r_err, output int lat,
                          output int n_rd, output int n_wr);
        int rd0, wr0;
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        r_data = resp_rdata;
        r_err  = resp_err;
        if (lat != 0) handshake();
        n_rd = rd_cnt - rd0;
        n_wr = wr_cnt - wr0;
    endtask

    logic [31:0] t_data;
    logic        t_err;
    int          t_lat, t_rd, t_wr;

    initial begin
        n_checks = 0; n_fails = 0;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rd", {31'd0, rd}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b1;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_resp_ready_noop", {31'd0, resp_valid}, 32'd0);
        resp_ready = 1'b0;

        // Write LED.
        do_req(1'b1, 32'h4000_0010, 32'h0000_00A5, t_data, t_err, t_lat, t_rd, t_wr);
        check("led_lat", t_lat, 3);
        check("led_wr_cycles", t_wr, 1);
        check("led_rd_cycles", t_rd, 0);
        check("led_strobe_addr", strobe_addr, 32'h4000_0010);
        check("led_err", {31'd0, t_err}, 32'd0);
        check("led_rdata", t_data, 32'd0);
        check("led_value", led_q, 32'h0000_00A5);

        // Read SWITCH.
        do_req(1'b0, 32'h4000_0014, 32'd0, t_data, t_err, t_lat, t_rd, t_wr);
        check("sw_lat", t_lat, 3);
        check("sw_rd_cycles", t_rd, 1);
        check("sw_wr_cycles", t_wr, 0);
        check("sw_rdata", t_data, 32'h0000_003C);
        check("sw_err", {31'd0, t_err}, 32'd0);

        // Read unacknowledged in-window hole.
        do_req(1'b0, 32'h4000_000C, 32'd0, t_data, t_err, t_lat, t_rd, t_wr);
        check("hole_rd_cycles", t_rd, 1);
        check("hole_rdata", t_data, 32'd0);
        check("hole_err", {31'd0, t_err}, 32'd1);

        // Last word of the window: reaches the bus, unacknowledged.
        do_req(1'b0, 32'h4000_001C, 32'd0, t_data, t_err, t_lat, t_rd, t_wr);
        check("last_lat", t_lat, 3);
        check("last_rd_cycles", t_rd, 1);
        check("last_err", {31'd0, t_err}, 32'd1);

        // Misaligned read is filtered.
        do_req(1'b0, 32'h4000_0002, 32'd0, t_data, t_err, t_lat, t_rd, t_wr);
        check("mis_lat", t_lat, 1);
        check("mis_strobes", t_rd + t_wr, 0);
        check("mis_err", {31'd0, t_err}, 32'd1);
        check("mis_rdata", t_data, 32'd0);

        // Write just past the window is filtered.
        do_req(1'b1, 32'h4000_0020, 32'h0000_00FF, t_data, t_err, t_lat, t_rd, t_wr);
        check("oow_hi_lat", t_lat, 1);
        check("oow_hi_strobes", t_rd + t_wr, 0);
        check("oow_hi_err", {31'd0, t_err}, 32'd1);
        check("oow_hi_led_kept", led_q, 32'h0000_00A5);

        // Read just below the window is filtered.
        do_req(1'b0, 32'h3FFF_FFFC, 32'd0, t_data, t_err, t_lat, t_rd, t_wr);
        check("oow_lo_lat", t_lat, 1);
        check("oow_lo_strobes", t_rd + t_wr, 0);
        check("oow_lo_err", {31'd0, t_err}, 32'd1);

        // Back-pressure: response held while a second request waits.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0004;
        @(posedge clk);
        #1 req_addr = 32'h4000_0018;
        wait_resp(t_lat);
        check("bp_first_lat", t_lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
            check("bp_resp_valid_held", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata_stable", resp_rdata, 32'h0000_1234);
        end
        handshake();
        check("bp_no_accept_on_handshake", {31'd0, req_ready}, 32'd1);
        check("bp_valid_dropped", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(t_lat);
        check("bp_second_lat", t_lat, 3);
        check("bp_second_rdata", resp_rdata, 32'h0000_0007);
        if (t_lat != 0) handshake();

        // Reset during ISSUE of a write to TH.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0000; req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_issue_wr_high", {31'd0, wr}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_issue_wr_drop", {31'd0, wr}, 32'd0);
        check("rst_issue_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_issue_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        check("rst_issue_th_untouched", th_q, 32'd0);
        do_req(1'b1, 32'h4000_0008, 32'h0000_0003, t_data, t_err, t_lat, t_rd, t_wr);
        check("post_rst_lat", t_lat, 3);
        check("post_rst_err", {31'd0, t_err}, 32'd0);
        check("post_rst_tcon", tcon_q, 32'h0000_0003);

        check("never_rd_and_wr", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
